// File: rtl/display_pkg.sv
// display_pkg: shared constants for the multiplexed hex display blocks.
package display_pkg;
    localparam int NIBBLE_W            = 4;
    localparam int DEFAULT_NUM_DIGITS  = 8;
    localparam int DEFAULT_REFRESH_DIV = 50000;
    localparam int MAX_DIGITS          = 8;
    localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;
endpackage

// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if: load/value/blanking inputs and scanned digit outputs of the display driver.
interface hex_display_scan_if #(parameter int NUM_DIGITS = 8);
    logic                  load;
    logic [31:0]           value;
    logic                  blank_lz;
    logic [3:0]            digit;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  frame_done;
    modport master (output load, value, blank_lz, input digit, digit_sel, frame_done);
    modport slave  (input load, value, blank_lz, output digit, digit_sel, frame_done);
endinterface

// File: rtl/refresh_tick.sv
// refresh_tick: one-cycle tick every DIV clocks, reusable by display/LED scanners.
module refresh_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick_o = cnt_q == CW'(DIV - 1);
    assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hex_display_scan.sv
// hex_display_scan: scans a captured hex value onto one nibble/enable pair at a time, updating only at frame wrap.
module hex_display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input logic clk,
    input logic reset,
    hex_display_scan_if.slave bus
);
    localparam int W  = NIBBLE_W * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    logic          tick, wrap, blank;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  disp_q, disp_d, pend_val_q, pend_val_d, shifted;
    logic          pend_flag_q, pend_flag_d, frame_done_q;
    refresh_tick #(.DIV(REFRESH_DIV)) u_tick (.clk(clk), .reset(reset), .tick_o(tick));
    // A load coincident with the wrap beats any older pending value.
    always_comb begin
        wrap        = tick && idx_q == IW'(NUM_DIGITS - 1);
        idx_d       = wrap ? '0 : tick ? idx_q + IW'(1) : idx_q;
        disp_d      = !wrap ? disp_q : bus.load ? bus.value[W-1:0] : pend_flag_q ? pend_val_q : disp_q;
        pend_val_d  = (bus.load && !wrap) ? bus.value[W-1:0] : pend_val_q;
        pend_flag_d = !wrap && (bus.load || pend_flag_q);
        shifted     = disp_q >> (NIBBLE_W * idx_q);
        blank       = bus.blank_lz && idx_q != '0 && shifted == '0;
    end
    assign bus.digit      = blank ? '0 : shifted[NIBBLE_W-1:0];
    assign bus.digit_sel  = blank ? DIGIT_OFF[NUM_DIGITS-1:0] : ~(NUM_DIGITS'(1) << idx_q);
    assign bus.frame_done = frame_done_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            disp_q       <= '0;
            pend_val_q   <= '0;
            pend_flag_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_val_q   <= pend_val_d;
            pend_flag_q  <= pend_flag_d;
            frame_done_q <= wrap;
        end
    end
endmodule
